anf_serializer: RTL and testbench

ANF_SERIALIZER -- requirements
Module: anf_serializer

---
 rtl/mobius_pkg.sv | 13 +
 rtl/anf_serializer_if.sv | 26 ++
 rtl/popcount_w.sv | 14 +
 rtl/anf_serializer.sv | 96 +++++++++
 tb/tb_anf_serializer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mobius_pkg.sv
// Shared definitions for the Mobius transform and its ANF serializer:
// default geometry and the serializer state encoding.
package mobius_pkg;
  localparam int N_DEF      = 8192;
  localparam int LOG2_N_DEF = 13;
  localparam int W_DEF      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/anf_serializer_if.sv
// Capture/serialize handshake bundle between transform, serializer and word sink.
interface anf_serializer_if import mobius_pkg::*; #(
  parameter int N      = N_DEF,
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int W      = W_DEF
);
  logic            in_valid;
  logic            in_ready;
  logic [0:N-1]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic            weight_valid;
  logic [LOG2_N:0] weight;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, weight_valid, weight
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, weight_valid, weight
  );
endinterface

// File: rtl/popcount_w.sv
// Combinational population count of one W-bit word.
module popcount_w #(
  parameter int W = 32
) (
  input  logic [W-1:0]         d,
  output logic [$clog2(W):0]   cnt
);
  localparam int CW = $clog2(W) + 1;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + CW'(d[i]);
  end
endmodule

// File: rtl/anf_serializer.sv
// Captures an N-bit ANF vector, streams it out as N/W words (coefficient 0 first)
// and reports the monomial count once the last word has been accepted.
module anf_serializer import mobius_pkg::*; #(
  parameter int N      = N_DEF,
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int W      = W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  anf_serializer_if.master bus
);
  localparam int LOG2W = $clog2(W);
  localparam int IW    = LOG2_N - LOG2W;
  localparam int AW    = LOG2_N + 1;
  localparam int CW    = LOG2W + 1;
  localparam logic [IW-1:0] LAST    = IW'(N / W - 1);
  localparam logic [IW-1:0] LAST_M1 = IW'(N / W - 2);

  state_t          state;
  logic [0:N-1]    cap;
  logic [IW-1:0]   idx;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   wt;
  logic            ov, ol, wv;
  logic [W-1:0]    word;
  logic [CW-1:0]   pc;
  logic [AW-1:0]   acc_nxt;

  // The captured vector shifts down by one word per transfer, so the
  // current word always sits at the front and no wide index mux is needed.
  for (genvar i = 0; i < W; i++) begin : g_word
    assign word[i] = cap[i];
  end

  popcount_w #(.W(W)) u_pc (
    .d   (word),
    .cnt (pc)
  );

  assign acc_nxt = acc + AW'(pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cap   <= '0;
      idx   <= '0;
      acc   <= '0;
      wt    <= '0;
      ov    <= 1'b0;
      ol    <= 1'b0;
      wv    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cap   <= bus.in_data;
            idx   <= '0;
            acc   <= '0;
            wt    <= '0;
            ov    <= 1'b1;
            ol    <= 1'b0;
            state <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            cap <= {cap[W:N-1], {W{1'b0}}};
            acc <= acc_nxt;
            if (idx == LAST) begin
              ov    <= 1'b0;
              ol    <= 1'b0;
              wt    <= acc_nxt;
              wv    <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + IW'(1);
              ol  <= (idx == LAST_M1);
            end
          end
        end
        DONE: begin
          wv    <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = ov;
  assign bus.out_data     = word;
  assign bus.out_last     = ol;
  assign bus.weight_valid = wv;
  assign bus.weight       = wt;
endmodule

// File: tb/tb_anf_serializer.sv
// Directed bench for anf_serializer: zero/ones/sparse/random vectors, stalls,
// held in_valid across two vectors, and a reset in the middle of a vector.
module tb_anf_serializer;
  import mobius_pkg::*;
  localparam int N = N_DEF, LOG2_N = LOG2_N_DEF, W = W_DEF, NW = N / W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  anf_serializer_if #(.N(N), .LOG2_N(LOG2_N), .W(W)) bus ();
  anf_serializer #(.N(N), .LOG2_N(LOG2_N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [0:N-1] vz, vo, vs, vr, vr2;
  logic [W-1:0] w0, w1, wl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] expw(input logic [0:N-1] v, input int k);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[k*W + i];
    return r;
  endfunction

  task automatic capture(input logic [0:N-1] v, input bit hold);
    int n = 0;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    chk("cap_wait", 64'(bus.in_ready), 64'd1);
    step();
    if (!hold) bus.in_valid = 1'b0;
    chk("cap_latency", 64'({bus.out_valid, bus.in_ready}), 64'b10);
  endtask

  task automatic drain(input logic [0:N-1] v, input bit stall);
    int k = 0;
    int cyc = 0;
    bit rdy;
    logic [LOG2_N:0] expwt;
    expwt = (LOG2_N+1)'($countones(v));
    while (k < NW && cyc < 4*NW + 50) begin
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      chk($sformatf("word%0d", k), 64'(bus.out_data), 64'(expw(v, k)));
      chk($sformatf("ctl%0d", k),
          64'({bus.out_valid, bus.out_last, bus.weight_valid, bus.in_ready}),
          64'({1'b1, (k == NW-1), 1'b0, 1'b0}));
      if (k == 0) w0 = bus.out_data;
      if (k == 1) w1 = bus.out_data;
      if (k == NW-1) wl = bus.out_data;
      step();
      if (rdy) k++;
      cyc++;
    end
    chk("drain_budget", 64'(k), 64'(NW));
    bus.out_ready = 1'b0;
    chk("done_ctl", 64'({bus.out_valid, bus.out_last, bus.weight_valid, bus.in_ready}), 64'b0010);
    chk("done_weight", 64'(bus.weight), 64'(expwt));
    step();
    chk("idle_ctl", 64'({bus.out_valid, bus.weight_valid, bus.in_ready}), 64'b001);
    chk("weight_hold", 64'(bus.weight), 64'(expwt));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    vz = '0;
    vo = '1;
    vs = '0;
    vs[0] = 1'b1; vs[33] = 1'b1; vs[N-1] = 1'b1;
    for (int i = 0; i < NW; i++) vr[i*W +: W] = W'($urandom());
    for (int i = 0; i < NW; i++) vr2[i*W +: W] = W'($urandom());

    // reset state
    step(); step();
    chk("rst_ctl", 64'({bus.out_valid, bus.out_last, bus.weight_valid, bus.in_ready}), 64'b0001);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_weight", 64'(bus.weight), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

    // all zeros
    capture(vz, 1'b0);
    drain(vz, 1'b0);
    chk("zero_weight", 64'(bus.weight), 64'd0);

    // all ones: weight 8192 uses the top bit of the count
    capture(vo, 1'b0);
    drain(vo, 1'b0);
    chk("ones_word0", 64'(w0), 64'hFFFF_FFFF);
    chk("ones_weight", 64'(bus.weight), 64'h2000);

    // sparse bits 0, 33, N-1
    capture(vs, 1'b0);
    drain(vs, 1'b0);
    chk("sparse_w0", 64'(w0), 64'h0000_0001);
    chk("sparse_w1", 64'(w1), 64'h0000_0002);
    chk("sparse_wl", 64'(wl), 64'h8000_0000);
    chk("sparse_weight", 64'(bus.weight), 64'd3);

    // random vector without and with stalls
    capture(vr, 1'b0);
    drain(vr, 1'b0);
    capture(vr, 1'b0);
    drain(vr, 1'b1);

    // in_valid held across two vectors; in_data changes mid-SEND are ignored
    capture(vr2, 1'b1);
    bus.in_data = vs;
    drain(vr2, 1'b0);
    capture(vs, 1'b0);
    drain(vs, 1'b0);

    // reset at word 100 of an all-ones vector
    capture(vo, 1'b0);
    bus.out_ready = 1'b1;
    repeat (100) step();
    chk("pre_rst_word", 64'(bus.out_data), 64'hFFFF_FFFF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 64'({bus.out_valid, bus.out_last, bus.weight_valid, bus.in_ready}), 64'b0001);
    chk("mid_rst_data", 64'(bus.out_data), 64'd0);
    chk("mid_rst_weight", 64'(bus.weight), 64'd0);
    step(); step();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_wv", 64'({bus.weight_valid, bus.out_valid, bus.in_ready}), 64'b001);
    end
    capture(vs, 1'b0);
    drain(vs, 1'b0);
    chk("after_rst_w0", 64'(w0), 64'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
